code_memory_arbiter: RTL

CODE_MEMORY_ARBITER -- requirements
Module: code_memory_arbiter

---
 rtl/code_memory_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/code_memory_arbiter.sv
// Two-master arbiter for a single-port code RAM: M0 fetches instructions, M1 reads/writes data.
// Optional write protection of the low code region is enabled with `define CODE_MEM_ARB_WRPROT_EN.
module code_memory_arbiter #(
    parameter int                unsigned ADDR_W        = 15,
    parameter int                unsigned MAX_BURST     = 4,
    parameter logic [ADDR_W-1:0]          PROTECT_LIMIT = 15'd8192
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_read,
    output logic              m0_waitrequest,
    output logic [31:0]       m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [3:0]        m1_byteenable,
    input  logic [31:0]       m1_writedata,
    output logic              m1_waitrequest,
    output logic [31:0]       m1_readdata,
    output logic              m1_readdatavalid,
    output logic [ADDR_W-1:0] ram_address,
    output logic [3:0]        ram_byteenable,
    output logic              ram_chipselect,
    output logic              ram_write,
    output logic [31:0]       ram_writedata,
    output logic              ram_clken,
    input  logic [31:0]       ram_readdata,
    output logic              wr_violation
);
    typedef enum logic [1:0] {IDLE, OWN_M0, OWN_M1} state_t;

    localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

    state_t            state_reg, state_next;
    logic [3:0]        burst_cnt_reg, burst_cnt_next;
    logic              last_m1_reg, last_m1_next;
    logic              grant0, grant1;
    logic              req0, req1;
    logic              prot_hit;
    logic              rvalid0_reg, rvalid1_reg;
    logic [ADDR_W-1:0] addr_hold_reg;
    logic [3:0]        be_hold_reg;
    logic [31:0]       wdata_hold_reg;

    assign req0 = m0_read;
    assign req1 = m1_read | m1_write;

    // Grant is decided combinationally so a winner is accepted in the cycle it requests.
    always_comb begin
        state_next     = state_reg;
        burst_cnt_next = burst_cnt_reg;
        last_m1_next   = last_m1_reg;
        grant0         = 1'b0;
        grant1         = 1'b0;
        if (reset_n) begin
            case (state_reg)
                OWN_M0: begin
                    if (req0 && (burst_cnt_reg < BURST_MAX || !req1)) grant0 = 1'b1;
                    else if (req1)                                   grant1 = 1'b1;
                end
                OWN_M1: begin
                    if (req1 && (burst_cnt_reg < BURST_MAX || !req0)) grant1 = 1'b1;
                    else if (req0)                                   grant0 = 1'b1;
                end
                default: begin
                    if (req0 && req1) begin
                        if (last_m1_reg) grant0 = 1'b1;
                        else             grant1 = 1'b1;
                    end else if (req0) begin
                        grant0 = 1'b1;
                    end else if (req1) begin
                        grant1 = 1'b1;
                    end
                end
            endcase

            // The count saturates so a lone owner can stream indefinitely.
            if (grant0) begin
                state_next     = OWN_M0;
                last_m1_next   = 1'b0;
                burst_cnt_next = (state_reg != OWN_M0) ? 4'd1 :
                                 (burst_cnt_reg < BURST_MAX) ? burst_cnt_reg + 4'd1 : burst_cnt_reg;
            end else if (grant1) begin
                state_next     = OWN_M1;
                last_m1_next   = 1'b1;
                burst_cnt_next = (state_reg != OWN_M1) ? 4'd1 :
                                 (burst_cnt_reg < BURST_MAX) ? burst_cnt_reg + 4'd1 : burst_cnt_reg;
            end else begin
                state_next     = IDLE;
                burst_cnt_next = 4'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            burst_cnt_reg  <= 4'd0;
            last_m1_reg    <= 1'b1;
            rvalid0_reg    <= 1'b0;
            rvalid1_reg    <= 1'b0;
            addr_hold_reg  <= '0;
            be_hold_reg    <= 4'd0;
            wdata_hold_reg <= 32'd0;
        end else begin
            state_reg      <= state_next;
            burst_cnt_reg  <= burst_cnt_next;
            last_m1_reg    <= last_m1_next;
            rvalid0_reg    <= grant0;
            rvalid1_reg    <= grant1 & m1_read & ~m1_write;
            addr_hold_reg  <= ram_address;
            be_hold_reg    <= ram_byteenable;
            wdata_hold_reg <= ram_writedata;
        end
    end

    // Idle RAM bus keeps its last address/data to avoid needless toggling.
    assign ram_address    = grant0 ? m0_address : (grant1 ? m1_address : addr_hold_reg);
    assign ram_byteenable = grant0 ? 4'hF : (grant1 ? m1_byteenable : be_hold_reg);
    assign ram_writedata  = grant1 ? m1_writedata : wdata_hold_reg;
    assign ram_chipselect = grant0 | grant1;
    assign ram_write      = grant1 & m1_write & ~prot_hit;
    assign ram_clken      = reset_n;

    assign m0_waitrequest   = ~grant0;
    assign m1_waitrequest   = ~grant1;
    assign m0_readdata      = ram_readdata;
    assign m1_readdata      = ram_readdata;
    // Gated so a read accepted just before reset never reports a return during reset.
    assign m0_readdatavalid = rvalid0_reg & reset_n;
    assign m1_readdatavalid = rvalid1_reg & reset_n;

`ifdef CODE_MEM_ARB_WRPROT_EN
    logic wr_violation_reg;

    assign prot_hit = (m1_address < PROTECT_LIMIT);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_violation_reg <= 1'b0;
        end else if (grant1 && m1_write && prot_hit) begin
            wr_violation_reg <= 1'b1;
        end
    end

    assign wr_violation = wr_violation_reg;
`else
    logic unused_prot_limit;

    assign unused_prot_limit = ^PROTECT_LIMIT;
    assign prot_hit          = 1'b0;
    assign wr_violation      = 1'b0;
`endif

endmodule
